// File: rtl/conv_pkg.sv
// Shared types and size helpers for the convolution frame controller and position counters.
package conv_pkg;

    localparam int unsigned RESULT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_WIN = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT_RES = 3'd3,
        ST_WRITE    = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    function automatic int unsigned out_dim(input int unsigned img, input int unsigned filt);
        return img - filt + 1;
    endfunction

    // At least one bit, so degenerate 1-wide dimensions still get a legal vector.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned addr_width(input int unsigned w, input int unsigned h);
        return cnt_width(w * h);
    endfunction

endpackage

// File: rtl/conv_pos_counter.sv
// Row/column/linear-address walker over a COLS x ROWS grid; saturates at the last position.
module conv_pos_counter import conv_pkg::*; #(
    parameter  int unsigned COLS   = 126,
    parameter  int unsigned ROWS   = 126,
    localparam int unsigned COL_W  = cnt_width(COLS),
    localparam int unsigned ROW_W  = cnt_width(ROWS),
    localparam int unsigned ADDR_W = addr_width(COLS, ROWS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              last_c
);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             last_col_c;

    assign last_col_c = (col == COL_W'(COLS - 1));
    assign last_c     = last_col_c && (row == ROW_W'(ROWS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (clr) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (inc && !last_c) begin
            addr <= addr + ADDR_W'(1);
            if (last_col_c) begin
                col <= '0;
                row <= row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer: walks every output position, fires the MAC, writes results out.
// Optional MAC watchdog enabled by defining CONV_WATCHDOG_EN.
module conv_frame_ctrl import conv_pkg::*; #(
    parameter  int unsigned IMAGE_WIDTH    = 128,
    parameter  int unsigned IMAGE_HEIGHT   = 128,
    parameter  int unsigned FILTER_SIZE    = 3,
`ifdef CONV_WATCHDOG_EN
    parameter  int unsigned TIMEOUT_CYCLES = 15,
`endif
    localparam int unsigned OUT_W  = out_dim(IMAGE_WIDTH, FILTER_SIZE),
    localparam int unsigned OUT_H  = out_dim(IMAGE_HEIGHT, FILTER_SIZE),
    localparam int unsigned ADDR_W = addr_width(OUT_W, OUT_H)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                win_valid,
    output logic                win_advance,
    output logic                conv_mult_en,
    input  logic [RESULT_W-1:0] conv_result,
    input  logic                conv_result_valid,
    output logic                out_we,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   out_addr,
    output logic [RESULT_W-1:0] out_data,
    output logic                busy,
    output logic                done,
    output logic                err
);

    state_e state_q, state_d;
    logic   pos_clr_c, pos_inc_c, pos_last_c, timeout_c;
    logic   win_advance_d, mult_en_d, out_we_d, busy_d, done_d;
    logic [RESULT_W-1:0] out_data_d;

    assign pos_clr_c = (state_q == ST_IDLE) && start;
    assign pos_inc_c = (state_q == ST_WRITE) && out_ready;

    conv_pos_counter #(
        .COLS (OUT_W),
        .ROWS (OUT_H)
    ) u_pos (
        .clk    (clk),
        .rst_n  (rst),
        .clr    (pos_clr_c),
        .inc    (pos_inc_c),
        .addr   (out_addr),
        .last_c (pos_last_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // A window seen while win_advance is high predates the shift, so it is skipped.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (start) state_d = ST_WAIT_WIN;
            ST_WAIT_WIN: if (win_valid && !win_advance) state_d = ST_ISSUE;
            ST_ISSUE:    state_d = ST_WAIT_RES;
            ST_WAIT_RES: begin
                if (conv_result_valid) state_d = ST_WRITE;
                else if (timeout_c)    state_d = ST_DONE;
            end
            ST_WRITE:    if (out_ready) state_d = pos_last_c ? ST_DONE : ST_WAIT_WIN;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so their flops line up with the state flop.
    always_comb begin
        win_advance_d = (state_q == ST_WRITE) && (state_d == ST_WAIT_WIN);
        mult_en_d     = (state_d == ST_ISSUE);
        out_we_d      = (state_d == ST_WRITE);
        busy_d        = (state_d != ST_IDLE);
        done_d        = (state_d == ST_DONE);
        out_data_d    = out_data;
        if ((state_q == ST_WAIT_RES) && conv_result_valid) out_data_d = conv_result;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_advance  <= 1'b0;
            conv_mult_en <= 1'b0;
            out_we       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            out_data     <= '0;
        end else begin
            win_advance  <= win_advance_d;
            conv_mult_en <= mult_en_d;
            out_we       <= out_we_d;
            busy         <= busy_d;
            done         <= done_d;
            out_data     <= out_data_d;
        end
    end

`ifdef CONV_WATCHDOG_EN
    localparam int unsigned WD_W = cnt_width(TIMEOUT_CYCLES);
    logic [WD_W-1:0] wd_q;

    assign timeout_c = (state_q == ST_WAIT_RES) && !conv_result_valid &&
                       (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    // Counts consecutive WAIT_RES cycles; err is sticky until the next frame start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q <= '0;
            err  <= 1'b0;
        end else begin
            wd_q <= ((state_q == ST_WAIT_RES) && (state_d == ST_WAIT_RES)) ? wd_q + WD_W'(1) : '0;
            if (pos_clr_c)      err <= 1'b0;
            else if (timeout_c) err <= 1'b1;
        end
    end
`else
    assign timeout_c = 1'b0;
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Directed bench for conv_frame_ctrl on a 5x5 image with a 3x3 kernel (3x3 outputs).
module tb_conv_frame_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        win_valid;
    logic        win_advance;
    logic        conv_mult_en;
    logic [15:0] conv_result;
    logic        conv_result_valid;
    logic        out_we;
    logic        out_ready;
    logic [3:0]  out_addr;
    logic [15:0] out_data;
    logic        busy;
    logic        done;
    logic        err;

    conv_frame_ctrl #(
        .IMAGE_WIDTH  (5),
        .IMAGE_HEIGHT (5),
        .FILTER_SIZE  (3)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .win_valid         (win_valid),
        .win_advance       (win_advance),
        .conv_mult_en      (conv_mult_en),
        .conv_result       (conv_result),
        .conv_result_valid (conv_result_valid),
        .out_we            (out_we),
        .out_ready         (out_ready),
        .out_addr          (out_addr),
        .out_data          (out_data),
        .busy              (busy),
        .done              (done),
        .err               (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Environment controls
    int kick = 0, stray_mode = 0, stall_addr = -1, stall_done = 0, ready_cnt = 0;
    int mac_cnt = 0, mac_idx = 0, mac_stall_idx = -1;
    // Monitor state
    int cyc = 0, start_cyc = 0;
    int wr_cnt = 0, wr_addr[16], wr_data[16], wr_cyc[16];
    int mult_cnt = 0, adv_cnt = 0, overlap = 0, first_adv_cyc = -1, last_mult_cyc = 0;
    int we_at_stall = 0, unstable = 0, done_cnt = 0, done_cyc = 0, done_err = 0, err_seen = 0;
    int hold_valid = 0, hold_addr = 0, hold_data = 0;

    // Shift unit, MAC model, output buffer and monitor, all evaluated at the falling edge.
    initial begin
        start = 1'b0; win_valid = 1'b1; conv_result = '0; conv_result_valid = 1'b0; out_ready = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            conv_result_valid = 1'b0;
            if (!rst) begin
                mac_cnt = 0; ready_cnt = 0; out_ready = 1'b1; hold_valid = 0;
            end else begin
                if (kick != 0) begin
                    kick = 0; start = 1'b1; start_cyc = cyc;
                    wr_cnt = 0; mult_cnt = 0; adv_cnt = 0; overlap = 0; first_adv_cyc = -1;
                    we_at_stall = 0; unstable = 0; done_cnt = 0; err_seen = 0;
                    mac_idx = 0; mac_cnt = 0; stall_done = 0; hold_valid = 0;
                end else if (stray_mode != 0 && win_advance) begin
                    start = 1'b1; conv_result_valid = 1'b1; conv_result = 16'hDEAD;
                end
                if (mac_cnt != 0) begin
                    mac_cnt--;
                    if (mac_cnt == 0 && mac_idx != mac_stall_idx) begin
                        conv_result_valid = 1'b1;
                        conv_result = 16'(100 + mac_idx);
                        mac_idx++;
                    end
                end
                if (conv_mult_en) mac_cnt = 2;
                if (out_we && int'(out_addr) == stall_addr && stall_done == 0) begin
                    stall_done = 1; ready_cnt = 3;
                end
                if (ready_cnt != 0) begin out_ready = 1'b0; ready_cnt--; end
                else out_ready = 1'b1;

                if (conv_mult_en) begin mult_cnt++; last_mult_cyc = cyc; end
                if (win_advance) begin
                    adv_cnt++;
                    if (first_adv_cyc < 0) first_adv_cyc = cyc;
                    if (conv_mult_en) overlap++;
                end
                if (out_we) begin
                    if (int'(out_addr) == stall_addr) we_at_stall++;
                    if (hold_valid != 0 && (int'(out_addr) != hold_addr || int'(out_data) != hold_data)) unstable++;
                    hold_valid = out_ready ? 0 : 1;
                    hold_addr = int'(out_addr); hold_data = int'(out_data);
                    if (out_ready && wr_cnt < 16) begin
                        wr_addr[wr_cnt] = int'(out_addr); wr_data[wr_cnt] = int'(out_data);
                        wr_cyc[wr_cnt] = cyc; wr_cnt++;
                    end
                end else begin
                    hold_valid = 0;
                end
                if (done) begin done_cnt++; done_cyc = cyc; done_err = int'(err); end
                if (err) err_seen++;
            end
        end
    end

    task automatic kick_frame;
        kick = 1;
        @(negedge clk); #1;
    endtask

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 400) begin @(negedge clk); #1; n++; end
        checks++;
        if (done_cnt == 0) begin fails++; $display("FAIL %s_timeout: no done after %0d cycles", name, n); end
        @(negedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({win_advance, conv_mult_en, out_we, busy, done, err} !== 6'b0) begin
            fails++; $display("FAIL reset_flags: got %b expected 000000", {win_advance, conv_mult_en, out_we, busy, done, err});
        end
        checks++;
        if (out_addr !== 4'd0) begin fails++; $display("FAIL reset_addr: got %0d expected 0", out_addr); end
        checks++;
        if (out_data !== 16'd0) begin fails++; $display("FAIL reset_data: got %0d expected 0", out_data); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({busy, out_we, conv_mult_en} !== 3'b0) begin
            fails++; $display("FAIL idle_no_start: got %b expected 000", {busy, out_we, conv_mult_en});
        end
    endtask

    task automatic test_basic_frame;
        kick_frame();
        wait_frame("basic");
        checks++;
        if (wr_cnt != 9) begin fails++; $display("FAIL basic_writes: got %0d expected 9", wr_cnt); end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (wr_addr[i] != i || wr_data[i] != 100 + i) begin
                fails++; $display("FAIL basic_write%0d: got addr %0d data %0d expected addr %0d data %0d",
                                  i, wr_addr[i], wr_data[i], i, 100 + i);
            end
        end
        checks++;
        if (wr_cyc[0] != start_cyc + 5) begin fails++; $display("FAIL first_write_latency: got %0d expected %0d", wr_cyc[0] - start_cyc, 5); end
        checks++;
        if (first_adv_cyc != wr_cyc[0] + 1) begin fails++; $display("FAIL advance_after_write: got %0d expected %0d", first_adv_cyc, wr_cyc[0] + 1); end
        checks++;
        if (mult_cnt != 9 || overlap != 0) begin fails++; $display("FAIL mult_en_count: got %0d overlap %0d expected 9 overlap 0", mult_cnt, overlap); end
        checks++;
        if (adv_cnt != 8) begin fails++; $display("FAIL advance_count: got %0d expected 8", adv_cnt); end
        checks++;
        if (done_cnt != 1 || done_cyc != wr_cyc[8] + 1) begin
            fails++; $display("FAIL done_timing: got count %0d cycle %0d expected count 1 cycle %0d", done_cnt, done_cyc, wr_cyc[8] + 1);
        end
        checks++;
        if (busy !== 1'b0 || out_addr !== 4'd8) begin fails++; $display("FAIL idle_after_frame: got busy %b addr %0d expected 0 8", busy, out_addr); end
        checks++;
        if (err_seen != 0) begin fails++; $display("FAIL err_quiet: got %0d expected 0", err_seen); end
    endtask

    task automatic test_ready_stall;
        stall_addr = 4;
        kick_frame();
        wait_frame("stall");
        stall_addr = -1;
        checks++;
        if (we_at_stall != 4 || unstable != 0) begin
            fails++; $display("FAIL stall_hold: got we cycles %0d unstable %0d expected 4 0", we_at_stall, unstable);
        end
        checks++;
        if (wr_cnt != 9 || wr_addr[4] != 4 || wr_data[4] != 104) begin
            fails++; $display("FAIL stall_write4: got n %0d addr %0d data %0d expected 9 4 104", wr_cnt, wr_addr[4], wr_data[4]);
        end
        checks++;
        if (mult_cnt != 9 || adv_cnt != 8) begin
            fails++; $display("FAIL stall_pulses: got mult %0d adv %0d expected 9 8", mult_cnt, adv_cnt);
        end
    endtask

    task automatic test_stray_inputs;
        stray_mode = 1;
        kick_frame();
        wait_frame("stray");
        stray_mode = 0;
        checks++;
        if (wr_cnt != 9 || done_cnt != 1 || mult_cnt != 9) begin
            fails++; $display("FAIL stray_counts: got writes %0d done %0d mult %0d expected 9 1 9", wr_cnt, done_cnt, mult_cnt);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (wr_addr[i] != i || wr_data[i] != 100 + i) begin
                fails++; $display("FAIL stray_write%0d: got addr %0d data %0d expected addr %0d data %0d",
                                  i, wr_addr[i], wr_data[i], i, 100 + i);
            end
        end
        checks++;
        if (out_data !== 16'd108) begin fails++; $display("FAIL stray_final_data: got %0d expected 108", out_data); end
    endtask

    task automatic test_reset_midframe;
        int n;
        kick_frame();
        n = 0;
        while (wr_cnt < 5 && n < 200) begin @(negedge clk); #1; n++; end
        checks++;
        if (wr_cnt != 5 || busy !== 1'b1) begin fails++; $display("FAIL mid_progress: got writes %0d busy %b expected 5 1", wr_cnt, busy); end
        rst = 1'b0;
        #1;
        checks++;
        if ({win_advance, conv_mult_en, out_we, busy, done, err} !== 6'b0 || out_addr !== 4'd0 || out_data !== 16'd0) begin
            fails++; $display("FAIL async_reset: got flags %b addr %0d data %0d expected 0 0 0",
                              {win_advance, conv_mult_en, out_we, busy, done, err}, out_addr, out_data);
        end
        @(negedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        kick_frame();
        wait_frame("restart");
        checks++;
        if (wr_cnt != 9 || wr_addr[0] != 0 || wr_data[0] != 100 || wr_addr[8] != 8) begin
            fails++; $display("FAIL restart_addr: got n %0d first %0d/%0d last %0d expected 9 0/100 8", wr_cnt, wr_addr[0], wr_data[0], wr_addr[8]);
        end
    endtask

`ifdef CONV_WATCHDOG_EN
    task automatic test_watchdog;
        mac_stall_idx = 2;
        kick_frame();
        wait_frame("watchdog");
        mac_stall_idx = -1;
        checks++;
        if (wr_cnt != 2 || mult_cnt != 3 || done_cnt != 1) begin
            fails++; $display("FAIL wd_counts: got writes %0d mult %0d done %0d expected 2 3 1", wr_cnt, mult_cnt, done_cnt);
        end
        checks++;
        if (done_cyc - last_mult_cyc != 16 || done_err != 1) begin
            fails++; $display("FAIL wd_timing: got %0d err %0d expected 16 1", done_cyc - last_mult_cyc, done_err);
        end
        checks++;
        if (err !== 1'b1) begin fails++; $display("FAIL wd_sticky: got %b expected 1", err); end
        kick_frame();
        @(negedge clk); #1;
        checks++;
        if (err !== 1'b0) begin fails++; $display("FAIL wd_clear: got %b expected 0", err); end
        wait_frame("wd_recover");
        checks++;
        if (wr_cnt != 9 || err_seen != 0) begin fails++; $display("FAIL wd_recover: got writes %0d err %0d expected 9 0", wr_cnt, err_seen); end
    endtask
`else
    task automatic test_err_tied;
        checks++;
        if (err !== 1'b0) begin fails++; $display("FAIL err_tied: got %b expected 0", err); end
    endtask
`endif

    initial begin
        rst = 1'b0;
        test_reset();
        test_basic_frame();
        test_ready_stall();
        test_stray_inputs();
        test_reset_midframe();
`ifdef CONV_WATCHDOG_EN
        test_watchdog();
`else
        test_err_tied();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

endmodule
